time_set_entry: RTL

TIME_SET_ENTRY -- requirements
Module: time_set_entry

---
 rtl/time_set_entry.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_entry.sv
// time_set_entry: button-driven HH:MM editor for the clock and alarm.
// Edits four BCD digits in turn, starting from the current time or from the stored
// alarm copy. It then pulses a one-cycle load strobe toward the clock core.
// Build option: define TIME_SET_ENTRY_AUTOREPEAT_EN to let a held up/down button keep stepping.
// Handshake: the buttons are level inputs, and a press is a 0->1 change seen at a clock edge.
// LD_time/LD_alarm are single-cycle strobes. No back-pressure exists, so the consumer
// must take H_set*/M_set* in the cycle the strobe is high.
module time_set_entry #(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int REPEAT_DELAY   = 3,
    parameter int REPEAT_RATE    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    input  logic       btn_cancel,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [2:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_set1,
    output logic [3:0] H_set0,
    output logic [2:0] M_set1,
    output logic [3:0] M_set0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       edit_active,
    output logic [1:0] digit_sel,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EDIT_H1 = 3'd1,
        EDIT_H0 = 3'd2,
        EDIT_M1 = 3'd3,
        EDIT_M0 = 3'd4,
        COMMIT  = 3'd5
    } state_e;

    localparam int B_TIME = 5, B_ALARM = 4, B_UP = 3, B_DOWN = 2, B_NEXT = 1, B_CANCEL = 0;

    state_e      state_q, state_d;
    logic [5:0]  prev_q, prev_d;
    logic [5:0]  btn_lvl, press;
    logic [1:0]  eh1_q, eh1_d, ah1_q, ah1_d;
    logic [3:0]  eh0_q, eh0_d, ah0_q, ah0_d;
    logic [2:0]  em1_q, em1_d, am1_q, am1_d;
    logic [3:0]  em0_q, em0_d, am0_q, am0_d;
    logic        target_q, target_d;        // 1 = editing the alarm
    logic [7:0]  to_q, to_d;
    logic        step_en, step_up, accepted;
    logic [3:0]  stepped;
    logic        rep_step, rep_step_up;
    logic        is_edit;

    assign btn_lvl = {btn_time, btn_alarm, btn_up, btn_down, btn_next, btn_cancel};
    assign press   = btn_lvl & ~prev_q;
    assign prev_d  = btn_lvl;
    assign is_edit = (state_q == EDIT_H1) || (state_q == EDIT_H0) ||
                     (state_q == EDIT_M1) || (state_q == EDIT_M0);

    // Step one digit up or down, wrapping within 0..max_v.
    function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic [3:0] max_v,
                                             input logic up);
        if (up) return (v >= max_v) ? 4'd0 : v + 4'd1;
        else    return (v == 4'd0) ? max_v : v - 4'd1;
    endfunction

`ifdef TIME_SET_ENTRY_AUTOREPEAT_EN
    logic       rep_en_q, rep_en_d, rep_dir_q, rep_dir_d, rep_armed_q, rep_armed_d;
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       rep_held;

    assign rep_held    = rep_dir_q ? btn_up : btn_down;
    assign rep_step_up = rep_dir_q;

    // Auto-repeat timer: first step after REPEAT_DELAY held cycles, then every REPEAT_RATE cycles.
    always_comb begin
        rep_en_d    = rep_en_q;
        rep_dir_d   = rep_dir_q;
        rep_armed_d = rep_armed_q;
        rep_cnt_d   = rep_cnt_q;
        rep_step    = 1'b0;
        if (!is_edit || press[B_CANCEL] || press[B_NEXT]) begin
            rep_en_d = 1'b0; rep_armed_d = 1'b0; rep_cnt_d = 8'd0;
        end else if (press[B_UP] || press[B_DOWN]) begin
            rep_en_d = 1'b1; rep_dir_d = press[B_UP]; rep_armed_d = 1'b0; rep_cnt_d = 8'd0;
        end else if (rep_en_q && rep_held) begin
            if (({1'b0, rep_cnt_q} + 9'd1) >= (rep_armed_q ? 9'(REPEAT_RATE) : 9'(REPEAT_DELAY))) begin
                rep_step    = 1'b1;
                rep_armed_d = 1'b1;
                rep_cnt_d   = 8'd0;
            end else begin
                rep_cnt_d = rep_cnt_q + 8'd1;
            end
        end else begin
            rep_en_d = 1'b0; rep_armed_d = 1'b0; rep_cnt_d = 8'd0;
        end
    end

    // Auto-repeat registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_en_q    <= 1'b0;
            rep_dir_q   <= 1'b0;
            rep_armed_q <= 1'b0;
            rep_cnt_q   <= 8'd0;
        end else begin
            rep_en_q    <= rep_en_d;
            rep_dir_q   <= rep_dir_d;
            rep_armed_q <= rep_armed_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end
`else
    logic unused_repeat_params;
    assign unused_repeat_params = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);
    assign rep_step    = 1'b0;
    assign rep_step_up = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Datapath registers: button history, edit digits, alarm copy, target, timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q   <= 6'd0;
            eh1_q    <= 2'd0; eh0_q <= 4'd0; em1_q <= 3'd0; em0_q <= 4'd0;
            ah1_q    <= 2'd0; ah0_q <= 4'd0; am1_q <= 3'd0; am0_q <= 4'd0;
            target_q <= 1'b0;
            to_q     <= 8'd0;
        end else begin
            prev_q   <= prev_d;
            eh1_q    <= eh1_d; eh0_q <= eh0_d; em1_q <= em1_d; em0_q <= em0_d;
            ah1_q    <= ah1_d; ah0_q <= ah0_d; am1_q <= am1_d; am0_q <= am0_d;
            target_q <= target_d;
            to_q     <= to_d;
        end
    end

    // Next state plus digit editing. Inside an edit state, one press per cycle acts,
    // in the order cancel > next > up > down > repeat.
    always_comb begin
        state_d  = state_q;
        eh1_d    = eh1_q; eh0_d = eh0_q; em1_d = em1_q; em0_d = em0_q;
        ah1_d    = ah1_q; ah0_d = ah0_q; am1_d = am1_q; am0_d = am0_q;
        target_d = target_q;
        to_d     = to_q;
        step_en  = 1'b0;
        step_up  = 1'b0;
        accepted = 1'b0;
        stepped  = 4'd0;
        unique case (state_q)
            IDLE: begin
                to_d = 8'd0;
                if (press[B_TIME]) begin
                    state_d = EDIT_H1; target_d = 1'b0;
                    eh1_d = cur_H1; eh0_d = cur_H0; em1_d = cur_M1; em0_d = cur_M0;
                end else if (press[B_ALARM]) begin
                    state_d = EDIT_H1; target_d = 1'b1;
                    eh1_d = ah1_q; eh0_d = ah0_q; em1_d = am1_q; em0_d = am0_q;
                end
            end
            EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0: begin
                accepted = 1'b1;
                if (press[B_CANCEL]) begin
                    state_d = IDLE;
                end else if (press[B_NEXT]) begin
                    unique case (state_q)
                        EDIT_H1: state_d = EDIT_H0;
                        EDIT_H0: state_d = EDIT_M1;
                        EDIT_M1: state_d = EDIT_M0;
                        default: state_d = COMMIT;
                    endcase
                end else if (press[B_UP]) begin
                    step_en = 1'b1; step_up = 1'b1;
                end else if (press[B_DOWN]) begin
                    step_en = 1'b1; step_up = 1'b0;
                end else if (rep_step) begin
                    step_en = 1'b1; step_up = rep_step_up;
                end else begin
                    accepted = 1'b0;
                end
                if (accepted) begin
                    to_d = 8'd0;
                end else if (({1'b0, to_q} + 9'd1) >= 9'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    to_d    = 8'd0;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (target_q) begin
                    ah1_d = eh1_q; ah0_d = eh0_q; am1_d = em1_q; am0_d = em0_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (step_en) begin
            unique case (state_q)
                EDIT_H1: begin
                    stepped = wrap_step({2'b00, eh1_q}, 4'd2, step_up);
                    eh1_d   = stepped[1:0];
                    // Moving into the 20s pulls an out-of-range hour digit down to 3.
                    if (stepped[1:0] == 2'd2 && eh0_q > 4'd3) eh0_d = 4'd3;
                end
                EDIT_H0: begin
                    stepped = wrap_step(eh0_q, (eh1_q == 2'd2) ? 4'd3 : 4'd9, step_up);
                    eh0_d   = stepped;
                end
                EDIT_M1: begin
                    stepped = wrap_step({1'b0, em1_q}, 4'd5, step_up);
                    em1_d   = stepped[2:0];
                end
                EDIT_M0: begin
                    stepped = wrap_step(em0_q, 4'd9, step_up);
                    em0_d   = stepped;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        edit_active = is_edit;
        digit_sel   = 2'd0;
        LD_time     = (state_q == COMMIT) && !target_q;
        LD_alarm    = (state_q == COMMIT) && target_q;
        state_dbg   = state_q;
        unique case (state_q)
            EDIT_H0: digit_sel = 2'd1;
            EDIT_M1: digit_sel = 2'd2;
            EDIT_M0: digit_sel = 2'd3;
            default: digit_sel = 2'd0;
        endcase
    end

    assign H_set1 = eh1_q;
    assign H_set0 = eh0_q;
    assign M_set1 = em1_q;
    assign M_set0 = em0_q;

endmodule
